// File: rtl/rc_ladder_pkg.sv
// Shared types and helpers for the RC ladder filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rc_ladder_pkg;

    typedef enum logic {
        BUFFERED = 1'b0,
        LOADED   = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Smallest shift that keeps the coupled ladder's explicit update stable.
    localparam int MIN_LOADED_SHIFT = 2;

    // Working width for saturation; callers sign-extend into it.
    localparam int SAT_W = 32;

    // Clamp a wide signed value to the signed range of a dw-bit word.
    function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] x,
                                                       input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (dw - 1)) - SAT_W'(1));
        lo = -hi - SAT_W'(1);
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/rc_ladder_filter_alu.sv
// Single-node forward-Euler update: new b from neighbours a (left) and c (right).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is committed.
module rc_node_alu
    import rc_ladder_pkg::*;
#(
    parameter int DW      = 16,
    parameter int SHIFT_W = 4
) (
    input  logic signed [DW-1:0]      a,
    input  logic signed [DW-1:0]      b,
    input  logic signed [DW-1:0]      c,
    input  logic                      last,
    input  mode_t                     mode,
    input  logic        [SHIFT_W-1:0] ks,
    output logic signed [DW-1:0]      b_new
);

    // Three guard bits hold a - 2b + c and b + step without wrap.
    localparam int EW = DW + 3;

    logic signed [EW-1:0]      a_x;
    logic signed [EW-1:0]      b_x;
    logic signed [EW-1:0]      c_x;
    logic signed [EW-1:0]      d;
    logic signed [EW-1:0]      step;
    logic signed [EW-1:0]      sum;
    logic        [SHIFT_W-1:0] ks_eff;

    // Difference, floor-shifted gain and saturated accumulate.
    always_comb begin
        a_x = {{3{a[DW-1]}}, a};
        b_x = {{3{b[DW-1]}}, b};
        c_x = {{3{c[DW-1]}}, c};

        ks_eff = ks;
        if (mode == LOADED && ks < SHIFT_W'(MIN_LOADED_SHIFT)) begin
            ks_eff = SHIFT_W'(MIN_LOADED_SHIFT);
        end

        if (mode == LOADED && !last) begin
            d = a_x - (b_x <<< 1) + c_x;
        end else begin
            d = a_x - b_x;
        end

        // Arithmetic shift floors toward -inf; huge shifts leave only the sign.
        step  = d >>> ks_eff;
        sum   = b_x + step;
        b_new = DW'(sat_dw(SAT_W'(sum), DW));
    end

endmodule

// File: rtl/rc_ladder_filter.sv
// Time-multiplexed fixed-point RC ladder (buffered cascade or loaded ladder), one node per cycle.
// Latency: accept at edge t, out_valid sampled high at edge t+STAGES+1; one sample per STAGES+2 cycles.
// Backpressure: in_ready only in IDLE; out_valid/out_data held until out_ready; clr drops the sample.
module rc_ladder_filter
    import rc_ladder_pkg::*;
#(
    parameter int DW      = 16,
    parameter int STAGES  = 3,
    parameter int SHIFT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   mode,
    input  logic [SHIFT_W-1:0]     k_shift,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [STAGES*DW-1:0]   node_taps,
    output logic                   busy
);

    localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    state_t                    state_q;
    state_t                    state_d;
    logic [IDX_W-1:0]          idx_q;
    logic [STAGES-1:0][DW-1:0] node_q;
    logic signed [DW-1:0]      in_q;
    logic signed [DW-1:0]      prev_old_q;
    logic signed [DW-1:0]      out_q;
    mode_t                     mode_q;
    logic [SHIFT_W-1:0]        ks_q;

    logic signed [DW-1:0]      alu_a;
    logic signed [DW-1:0]      alu_b;
    logic signed [DW-1:0]      alu_c;
    logic signed [DW-1:0]      alu_new;
    logic                      last_idx;
    logic                      accept;

    assign node_taps = node_q;
    assign out_data  = out_q;

    // Next state and handshake outputs; clr wins and hides both handshakes.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy = 1'b1;
                if (last_idx) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d   = IDLE;
            accept    = 1'b0;
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand select: left neighbour is the input or the saved old value, right is still old.
    always_comb begin
        alu_a = (idx_q == '0) ? in_q : prev_old_q;
        alu_b = '0;
        alu_c = '0;
        for (int j = 0; j < STAGES; j++) begin
            if (idx_q == IDX_W'(j)) begin
                alu_b = node_q[j];
            end
        end
        for (int j = 0; j < STAGES - 1; j++) begin
            if (idx_q == IDX_W'(j)) begin
                alu_c = node_q[j+1];
            end
        end
        last_idx = (idx_q == IDX_W'(STAGES - 1));
    end

    rc_node_alu #(
        .DW      (DW),
        .SHIFT_W (SHIFT_W)
    ) u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .c     (alu_c),
        .last  (last_idx),
        .mode  (mode_q),
        .ks    (ks_q),
        .b_new (alu_new)
    );

    // Sample latch, node register file and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_q     <= '0;
            in_q       <= '0;
            prev_old_q <= '0;
            out_q      <= '0;
            idx_q      <= '0;
            mode_q     <= BUFFERED;
            ks_q       <= '0;
        end else if (clr) begin
            node_q     <= '0;
            prev_old_q <= '0;
            out_q      <= '0;
            idx_q      <= '0;
        end else begin
            if (accept) begin
                in_q   <= in_data;
                mode_q <= mode_t'(mode);
                ks_q   <= k_shift;
                idx_q  <= '0;
            end
            if (state_q == UPDATE) begin
                for (int j = 0; j < STAGES; j++) begin
                    if (idx_q == IDX_W'(j)) begin
                        node_q[j] <= alu_new;
                    end
                end
                // Old value of this node is the left neighbour of the next one.
                prev_old_q <= alu_b;
                if (last_idx) begin
                    out_q <= alu_new;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rc_ladder_filter.sv
module tb_rc_ladder_filter;

    localparam int DW      = 16;
    localparam int STAGES  = 3;
    localparam int SHIFT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  clr = 1'b0;
    logic                  mode = 1'b0;
    logic [SHIFT_W-1:0]    k_shift = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DW-1:0]         in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [DW-1:0]         out_data;
    logic [STAGES*DW-1:0]  node_taps;
    logic                  busy;

    int total = 0;
    int bad   = 0;
    int mv[STAGES+1];
    int exp_q[$];

    always #5 clk = ~clk;

    rc_ladder_filter #(
        .DW      (DW),
        .STAGES  (STAGES),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .mode      (mode),
        .k_shift   (k_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .node_taps (node_taps),
        .busy      (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Whole-sample Jacobi model: every node sees the values from before this sample.
    task automatic model_step(input int din, input bit m, input int k);
        int old[STAGES+1];
        int ks;
        int d;
        old    = mv;
        old[0] = din;
        ks = (m && k < 2) ? 2 : k;
        for (int i = 1; i <= STAGES; i++) begin
            if (m && i < STAGES) d = old[i-1] - 2 * old[i] + old[i+1];
            else                 d = old[i-1] - old[i];
            mv[i] = sat16(old[i] + (d >>> ks));
        end
        exp_q.push_back(mv[STAGES]);
    endtask

    function automatic logic [STAGES*DW-1:0] model_taps();
        logic [STAGES*DW-1:0] t;
        t = '0;
        for (int i = 1; i <= STAGES; i++) t[(i-1)*DW +: DW] = DW'(mv[i]);
        return t;
    endfunction

    task automatic model_clear();
        for (int i = 0; i <= STAGES; i++) mv[i] = 0;
    endtask

    task automatic drive(input int din, input bit m, input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        in_data  = din[DW-1:0];
        mode     = m;
        k_shift  = k[SHIFT_W-1:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called at a negedge with out_valid high; pops and compares, then handshakes.
    task automatic take_output();
        int e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", out_valid, 0);
        end else begin
            e = exp_q.pop_front();
            check("out_data", $signed(out_data), e);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
    endtask

    task automatic run(input int din, input bit m, input int k, input string tag);
        drive(din, m, k);
        model_step(din, m, k);
        wait_valid();
        if (out_valid) take_output();
        check({tag, "_taps"}, node_taps, model_taps());
    endtask

    task automatic clear_all();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();

        // Reset state.
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_taps", node_taps, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Buffered cascade, k=1.
        clear_all();
        run(16384, 1'b0, 1, "buf1");
        run(16384, 1'b0, 1, "buf2");
        run(16384, 1'b0, 1, "buf3");
        check("buf_final_taps", node_taps, {16'd2048, 16'd8192, 16'd14336});

        // Loaded ladder, k=2.
        clear_all();
        run(16384, 1'b1, 2, "ld1");
        check("ld_s1_taps", node_taps, {16'd0, 16'd0, 16'd4096});
        run(16384, 1'b1, 2, "ld2");
        check("ld_s2_taps", node_taps, {16'd0, 16'd1024, 16'd6144});
        run(16384, 1'b1, 2, "ld3");
        check("ld_s3_taps", node_taps, {16'd256, 16'd2048, 16'd7424});

        // Loaded ladder, k=0 clamps to 2.
        clear_all();
        run(16384, 1'b1, 0, "ldk0_1");
        run(16384, 1'b1, 0, "ldk0_2");
        run(16384, 1'b1, 0, "ldk0_3");
        check("ldk0_taps", node_taps, {16'd256, 16'd2048, 16'd7424});

        // Floor shift of a negative difference.
        clear_all();
        run(-1, 1'b0, 1, "neg");
        check("neg_taps", node_taps, {16'd0, 16'd0, 16'hFFFF});

        // Latency: out_valid low through edge t+3, high when sampled at edge t+4.
        clear_all();
        drive(12000, 1'b0, 1);
        model_step(12000, 1'b0, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("lat_low", out_valid, 0);
        end
        @(negedge clk);
        check("lat_high", out_valid, 1);
        if (out_valid) take_output();

        // Back-to-back throughput: next accept right after the handshake.
        @(negedge clk);
        check("thru_in_ready", in_ready, 1);

        // Backpressure: hold out_ready low for 5 cycles.
        out_ready = 1'b0;
        drive(5000, 1'b1, 3);
        model_step(5000, 1'b1, 3);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", $signed(out_data), exp_q.size() > 0 ? exp_q[0] : 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
            @(negedge clk);
        end
        if (out_valid) take_output();
        @(negedge clk);
        check("bp_rel_in_ready", in_ready, 1);
        check("bp_rel_out_valid", out_valid, 0);
        check("bp_rel_busy", busy, 0);

        // Clear during the second UPDATE cycle drops the sample.
        drive(8000, 1'b1, 2);
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_clear();
        @(negedge clk);
        check("clr_taps", node_taps, 0);
        check("clr_busy", busy, 0);
        check("clr_in_ready", in_ready, 1);
        check("clr_out_data", out_data, 0);
        for (int i = 0; i < 5; i++) begin
            check("clr_no_valid", out_valid, 0);
            @(negedge clk);
        end

        // Async reset while OUTPUT is stalled.
        out_ready = 1'b0;
        drive(16384, 1'b0, 1);
        wait_valid();
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_taps", node_taps, 0);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
